// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: bus widths, mem_op codes,
// FSM state encodings and small op-class decode helpers.
package mem_access_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = 4;
  localparam int REG_W  = 5;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: byte-enable and data replication for stores,
// lane select with sign/zero extension for loads. Purely combinational.
module mem_lane_align import mem_access_pkg::*; (
  input  logic [OP_W-1:0]   mem_op,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] load_word,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select (offset 0 is the most significant byte) and per-op shaping
  always_comb begin
    case (offset)
      2'd0:    byte_sel = load_word[31:24];
      2'd1:    byte_sel = load_word[23:16];
      2'd2:    byte_sel = load_word[15:8];
      default: byte_sel = load_word[7:0];
    endcase
    // Halfword uses offset[1] only, so a stray offset[0] never shifts lanes
    half_sel  = offset[1] ? load_word[15:0] : load_word[31:16];
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    case (mem_op)
      OP_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      OP_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      OP_SB: begin
        be    = 4'b1000 >> offset;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be    = offset[1] ? 4'b0011 : 4'b1100;
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues one data-memory request per load/store, stalls the
// front of the pipeline until the ack arrives, and presents the result
// to MEM/WB. Optional misalignment trap: define MEM_ALIGN_CHECK_EN.
module mem_access import mem_access_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [REG_W-1:0]  rd_addr_i,
  input  logic              rd_write_i,
  input  logic [OP_W-1:0]   mem_op_i,
  output logic [DATA_W-1:0] write_data_o,
  output logic [REG_W-1:0]  rd_addr_o,
  output logic              rd_write_o,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [BE_W-1:0]   dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_ack_i,
  output logic              align_err_o
);

  state_e state_q, state_d;

  logic              load_op, store_op, mem_valid, misalign, start;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [BE_W-1:0]   be_q;
  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_wdata, lane_load;

  assign load_op   = is_load(mem_op_i);
  assign store_op  = is_store(mem_op_i);
  assign mem_valid = load_op | store_op;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign =
    (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH)) && alu_result_i[0]) ||
    (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (alu_result_i[1:0] != 2'b00));
  assign align_err_o = ~rst & (state_q == S_IDLE) & mem_valid & misalign;
`else
  assign misalign    = 1'b0;
  assign align_err_o = 1'b0;
`endif

  // A misaligned op (when trapped) never starts a request
  assign start = mem_valid & ~misalign;

  // EX/MEM is held during the access, so the same inputs shape both the
  // outgoing store data and the returning load data
  mem_lane_align u_lane (
    .mem_op     (mem_op_i),
    .offset     (alu_result_i[1:0]),
    .store_data (store_data_i),
    .load_word  (rdata_q),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_BUSY;
      S_BUSY:  if (dmem_ack_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered request strobe, high for exactly the BUSY cycles
  always_ff @(posedge clk) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= (state_d == S_BUSY);
  end

  // Request payload frozen on entry to BUSY so the bus stays stable
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && start) begin
      addr_q  <= {alu_result_i[ADDR_W-1:2], 2'b00};
      be_q    <= lane_be;
      wdata_q <= lane_wdata;
      we_q    <= store_op;
    end
  end

  // Capture read data on the ack; acks outside BUSY are ignored
  always_ff @(posedge clk) begin
    if (rst)                                rdata_q <= '0;
    else if ((state_q == S_BUSY) && dmem_ack_i) rdata_q <= dmem_rdata_i;
  end

  // Output logic: stall, bubble insertion and write-back selection
  always_comb begin
    stall_o      = 1'b0;
    rd_write_o   = 1'b0;
    write_data_o = alu_result_i;
    rd_addr_o    = rd_addr_i;
    case (state_q)
      S_IDLE: begin
        stall_o    = start;
        rd_write_o = rd_write_i & ~mem_valid;
      end
      S_BUSY: stall_o = 1'b1;
      S_DONE: begin
        if (load_op) begin
          write_data_o = lane_load;
          rd_write_o   = rd_write_i;
        end
      end
      default: ;
    endcase
    if (rst) begin
      stall_o      = 1'b0;
      rd_write_o   = 1'b0;
      write_data_o = '0;
      rd_addr_o    = '0;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = req_q & we_q & ~rst;
  assign dmem_be_o    = rst ? '0 : be_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: reset behaviour, pass-through, loads,
// stores, ack timing, stray acks and reset during an outstanding request.
module tb_mem_access;

  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LBU = 4'd2, LH = 4'd3,
                         LHU = 4'd4, LW = 4'd5, SB = 4'd6, SH = 4'd7, SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_i, store_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_write_i;
  logic [3:0]  mem_op_i;
  logic [31:0] write_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_write_o, stall_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        align_err_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result_i (alu_result_i),
    .store_data_i (store_data_i),
    .rd_addr_i    (rd_addr_i),
    .rd_write_i   (rd_write_i),
    .mem_op_i     (mem_op_i),
    .write_data_o (write_data_o),
    .rd_addr_o    (rd_addr_o),
    .rd_write_o   (rd_write_o),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_be_o    (dmem_be_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dmem_ack_i   (dmem_ack_i),
    .align_err_o  (align_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw);
    mem_op_i     = op;
    alu_result_i = addr;
    store_data_i = sd;
    rd_addr_i    = rd;
    rd_write_i   = rw;
  endtask

  // Run one access from its IDLE cycle; returns at the negedge of the
  // first non-stalled cycle (DONE) with a snapshot of the bus in BUSY.
  task automatic do_access(input int ack_dly, input logic [31:0] rdata,
                           output int stalls, output logic [31:0] b_addr,
                           output logic [3:0] b_be, output logic [31:0] b_wdata,
                           output logic b_req, output logic b_we, output logic rdw_stall);
    bit done;
    done = 1'b0; stalls = 0; rdw_stall = 1'b0;
    b_addr = '0; b_be = '0; b_wdata = '0; b_req = 1'b0; b_we = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == ack_dly + 1) begin dmem_ack_i = 1'b1; dmem_rdata_i = rdata; end
      else                  begin dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0; end
      @(negedge clk);
      if (c == 1) begin
        b_addr = dmem_addr_o; b_be = dmem_be_o; b_wdata = dmem_wdata_o;
        b_req = dmem_req_o; b_we = dmem_we_o;
      end
      if (stall_o) begin
        stalls++;
        rdw_stall = rdw_stall | rd_write_o;
        step();
      end else begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_test(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input int ack_dly, input logic [31:0] rdata,
                           input logic [31:0] exp_data, input int exp_stalls,
                           input logic [31:0] exp_addr);
    int st; logic [31:0] ba, bw; logic [3:0] bb; logic br, bwe, rs;
    issue(op, addr, 32'h0, 5'd9, 1'b1);
    do_access(ack_dly, rdata, st, ba, bb, bw, br, bwe, rs);
    check({tag, "_stalls"}, st, exp_stalls);
    check({tag, "_req"}, {31'd0, br}, 32'd1);
    check({tag, "_we"}, {31'd0, bwe}, 32'd0);
    check({tag, "_be"}, {28'd0, bb}, 32'hF);
    check({tag, "_addr"}, ba, exp_addr);
    check({tag, "_bubble"}, {31'd0, rs}, 32'd0);
    check({tag, "_wdata_out"}, write_data_o, exp_data);
    check({tag, "_rdwrite"}, {31'd0, rd_write_o}, 32'd1);
    check({tag, "_rdaddr"}, {27'd0, rd_addr_o}, 32'd9);
    step();
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic store_test(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
    int st; logic [31:0] ba, bw; logic [3:0] bb; logic br, bwe, rs;
    issue(op, addr, sd, 5'd4, 1'b1);
    do_access(0, 32'h0, st, ba, bb, bw, br, bwe, rs);
    check({tag, "_stalls"}, st, 2);
    check({tag, "_req"}, {31'd0, br}, 32'd1);
    check({tag, "_we"}, {31'd0, bwe}, 32'd1);
    check({tag, "_be"}, {28'd0, bb}, {28'd0, exp_be});
    check({tag, "_wdata"}, bw, exp_wdata);
    check({tag, "_addr"}, ba, exp_addr);
    check({tag, "_bubble"}, {31'd0, rs}, 32'd0);
    check({tag, "_rdwrite_done"}, {31'd0, rd_write_o}, 32'd0);
    step();
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    issue(ADD_OP(), 32'h5, 32'h0, 5'd3, 1'b1);
    step();
    step();
    // Outputs forced low while reset is held
    @(negedge clk);
    check("rst_wdata", write_data_o, 32'h0);
    check("rst_rdaddr", {27'd0, rd_addr_o}, 32'd0);
    check("rst_rdwrite", {31'd0, rd_write_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_req", {31'd0, dmem_req_o}, 32'd0);
    check("rst_we", {31'd0, dmem_we_o}, 32'd0);
    check("rst_be", {28'd0, dmem_be_o}, 32'd0);
    check("rst_alignerr", {31'd0, align_err_o}, 32'd0);
    step();
    rst = 1'b0;

    // Non-memory op passes straight through
    @(negedge clk);
    check("add_wdata", write_data_o, 32'h5);
    check("add_rdwrite", {31'd0, rd_write_o}, 32'd1);
    check("add_rdaddr", {27'd0, rd_addr_o}, 32'd3);
    check("add_stall", {31'd0, stall_o}, 32'd0);
    check("add_req", {31'd0, dmem_req_o}, 32'd0);
    step();

    load_test("lw", LW, 32'h100, 2, 32'hDEADBEEF, 32'hDEADBEEF, 4, 32'h100);
    load_test("lb", LB, 32'h103, 0, 32'h000000F0, 32'hFFFFFFF0, 2, 32'h100);
    load_test("lbu", LBU, 32'h103, 1, 32'h000000F0, 32'h000000F0, 3, 32'h100);
    load_test("lb0", LB, 32'h200, 0, 32'h7F00FF00, 32'h0000007F, 2, 32'h200);
    load_test("lh", LH, 32'h100, 0, 32'h80011234, 32'hFFFF8001, 2, 32'h100);
    load_test("lhu", LHU, 32'h102, 0, 32'h80019234, 32'h00009234, 2, 32'h100);

    store_test("sh", SH, 32'h102, 32'h1234ABCD, 4'b0011, 32'hABCDABCD, 32'h100);
    store_test("sh0", SH, 32'h100, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 32'h100);
    store_test("sb1", SB, 32'h101, 32'h0000005A, 4'b0100, 32'h5A5A5A5A, 32'h100);
    store_test("sb0", SB, 32'h104, 32'h000000C3, 4'b1000, 32'hC3C3C3C3, 32'h104);
    store_test("sw", SW, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h104);

`ifdef MEM_ALIGN_CHECK_EN
    issue(LW, 32'h102, 32'h0, 5'd6, 1'b1);
    @(negedge clk);
    check("mis_alignerr", {31'd0, align_err_o}, 32'd1);
    check("mis_stall", {31'd0, stall_o}, 32'd0);
    check("mis_rdwrite", {31'd0, rd_write_o}, 32'd0);
    check("mis_req", {31'd0, dmem_req_o}, 32'd0);
    step();
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("mis_req_after", {31'd0, dmem_req_o}, 32'd0);
    check("mis_alignerr_after", {31'd0, align_err_o}, 32'd0);
    step();
`else
    issue(LW, 32'h102, 32'h0, 5'd6, 1'b1);
    @(negedge clk);
    check("mis_alignerr_off", {31'd0, align_err_o}, 32'd0);
    step();
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    step();
    load_test("lw_unaligned", LW, 32'h102, 0, 32'h01020304, 32'h01020304, 2, 32'h100);
`endif

    // Stray ack while idle must change nothing
    issue(NONE, 32'h42, 32'h0, 5'd2, 1'b1);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h99;
    @(negedge clk);
    check("stray_stall", {31'd0, stall_o}, 32'd0);
    check("stray_wdata", write_data_o, 32'h42);
    check("stray_rdwrite", {31'd0, rd_write_o}, 32'd1);
    step();
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    @(negedge clk);
    check("stray_req", {31'd0, dmem_req_o}, 32'd0);
    check("stray_stall2", {31'd0, stall_o}, 32'd0);
    step();

    // Reset while a request is outstanding abandons it
    issue(LW, 32'h200, 32'h0, 5'd6, 1'b1);
    @(negedge clk);
    check("rb_stall_idle", {31'd0, stall_o}, 32'd1);
    step();
    @(negedge clk);
    check("rb_req_busy", {31'd0, dmem_req_o}, 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rb_stall_rst", {31'd0, stall_o}, 32'd0);
    check("rb_rdwrite_rst", {31'd0, rd_write_o}, 32'd0);
    step();
    rst = 1'b0;
    issue(NONE, 32'h0, 32'h0, 5'd6, 1'b0);
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h11111111;
    @(negedge clk);
    check("rb_req_after", {31'd0, dmem_req_o}, 32'd0);
    check("rb_stall_after", {31'd0, stall_o}, 32'd0);
    check("rb_rdwrite_after", {31'd0, rd_write_o}, 32'd0);
    check("rb_wdata_after", write_data_o, 32'h0);
    step();
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    @(negedge clk);
    check("rb_req_later", {31'd0, dmem_req_o}, 32'd0);
    check("rb_stall_later", {31'd0, stall_o}, 32'd0);
    step();
    load_test("lw_post_rst", LW, 32'h300, 0, 32'h0BADF00D, 32'h0BADF00D, 2, 32'h300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  function automatic logic [3:0] ADD_OP();
    return NONE;
  endfunction

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1);
  end

endmodule
